apb_lb_bridge: RTL
==================

# apb_lb_bridge

APB4 completer that converts each APB transfer into a single local-bus (LB) read or write request, then holds the APB access phase with `pready` low until the local bus responds. It sits directly downstream of the APB requester (testbench driver or SoC interconnect) and upstream of generated register maps that expose the LB port. It also adds address-alignment checking and an optional response timeout, both reported on `pslverr`.

## Interface
- `ADDR_W`, 12, APB/LB address width
- `DATA_W`, 32, data width; 32 or 64 only
- `STRB_W`, `DATA_W/8`, byte-strobe width
- `TIMEOUT_CYCLES`, 256, LB wait limit; range 2..65535; used only with the timeout macro
- `pclk`  in  1  clock; all logic on rising edge
- `preset`  in  1  reset; asynchronous, active-high
- `psel`, `penable`, `pwrite`  in  1  APB control
- `paddr`  in  ADDR_W  APB address
- `pwdata`  in  DATA_W  APB write data
- `pstrb`  in  STRB_W  APB write strobes
- `prdata`  out  DATA_W  read data; valid only while `pready`=1
- `pready`  out  1  transfer completion
- `pslverr`  out  1  error; valid only while `pready`=1
- `lb_addr`  out  ADDR_W  LB address, latched from `paddr`
- `lb_wdata`  out  DATA_W  LB write data
- `lb_wstrb`  out  STRB_W  LB write strobes
- `lb_wen`  out  1  LB write request; held until `lb_wready`
- `lb_wready`  in  1  LB write accepted
- `lb_ren`  out  1  LB read request; held until `lb_rvalid`
- `lb_rdata`  in  DATA_W  LB read data; sampled when `lb_rvalid`=1
- `lb_rvalid`  in  1  LB read data valid

## Operation
- States: IDLE, REQ, RESP.
- **IDLE**
  - On `psel`=1 and `penable`=0 (setup phase), latch `paddr`, `pwrite`, `pwdata` and `pstrb`.
  - If the address is misaligned (`paddr[$clog2(STRB_W)-1:0]` ≠ 0), go to RESP with the error flag set. No LB request is issued.
  - Otherwise go to REQ.
- **REQ**
  - Drive `lb_wen` (write) or `lb_ren` (read) continuously.
  - Write: the cycle `lb_wready`=1 ends REQ; go to RESP with error=0.
  - Read: the cycle `lb_rvalid`=1, register `lb_rdata` and go to RESP with error=0.
  - `lb_addr`, `lb_wdata` and `lb_wstrb` stay stable throughout REQ.
- **RESP**
  - `pready`=1 for exactly one cycle; `pslverr` = error flag.
  - `prdata` = captured data for reads, 0 for writes and for errors.
  - Next state is always IDLE.
- Reads ignore `pstrb`; `lb_wstrb` is driven as 0 during reads.
- A write with `pstrb`=0 is still forwarded to the LB.
- If `psel` drops mid-transfer (protocol violation), the LB request still completes and the FSM passes through RESP. No recovery beyond that is required.
- `lb_wready` or `lb_rvalid` arriving outside REQ is ignored.

## Timing
- Reset value is 0 on every output; state resets to IDLE, error flag to 0, timeout counter to 0.
- Reset asserted mid-transfer clears all outputs immediately (asynchronous); the LB request is abandoned.
- Cycle numbering: C0 = APB setup, C1 = first access cycle (`penable`=1).
- Aligned access:
  - `lb_wen`/`lb_ren` rise in C1.
  - If the LB responds in cycle Cn, `pready`=1 in Cn+1.
  - Minimum transfer is 3 cycles (C0–C2), with a zero-wait LB responding in C1.
- Misaligned access: `pready`=1, `pslverr`=1 in C1; a 2-cycle transfer.
- Back-to-back transfers: a new setup phase may occur in the cycle after RESP and is accepted from IDLE.
- All outputs are registered; there is no combinational path from APB inputs to APB outputs.

## Configuration
- Macro: `APB_LB_BRIDGE_TIMEOUT_EN`.
- Defined:
  - A counter runs while in REQ and clears on REQ entry.
  - When it reaches `TIMEOUT_CYCLES` with no LB response, the request is dropped and the FSM goes to RESP with `pslverr`=1 and `prdata`=0.
  - An LB response in the same cycle as expiry wins: no error is reported.
- Undefined: no counter exists, and REQ waits indefinitely.

## Structure
- Package `apb_lb_pkg` holds:
  - the state enum (`IDLE`, `REQ`, `RESP`);
  - default width constants;
  - the `TIMEOUT_CYCLES` default.
- One sub-module, `apb_lb_timeout`:
  - inputs: enable, clear;
  - output: expiry pulse;
  - counter width `$clog2(TIMEOUT_CYCLES+1)`;
  - instantiated only under the macro.

## Test plan
- Write `paddr`=0x004, data 0xDEADBEEF, strb 0xF, `lb_wready` tied 1:
  - `lb_wen`=1 in C1 only, with `lb_addr`=0x004, `lb_wdata`=0xDEADBEEF;
  - `pready`=1, `pslverr`=0 in C2.
- Read `paddr`=0x010, `lb_rvalid` with 0x12345678 five cycles after `lb_ren` rises:
  - `lb_ren` held for 6 cycles;
  - `pready`=1 the next cycle with `prdata`=0x12345678.
- Misaligned write `paddr`=0x006: no `lb_wen` at any time; `pready`=1, `pslverr`=1 in C1.
- Macro defined, `TIMEOUT_CYCLES`=16, `lb_wready` stuck 0:
  - `lb_wen` drops after 16 cycles;
  - `pready`=1, `pslverr`=1.
  - Same case with the macro undefined: `pready` stays 0 for 1000 cycles.
- `preset` pulsed while in REQ: all outputs 0 within the reset cycle; the following write to 0x008 completes normally.
- Back-to-back write 0x0 = 0xA5 then read 0x0 (LB model returns the stored value): `prdata`=0xA5 with no idle gap beyond the APB protocol.

Source files
------------

// File: rtl/apb_lb_pkg.sv
// Shared types and default configuration for the APB to local-bus bridge.
package apb_lb_pkg;

  localparam int unsigned DefAddrW         = 12;
  localparam int unsigned DefDataW         = 32;
  localparam int unsigned DefTimeoutCycles = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/apb_lb_bridge_if.sv
// APB completer and local-bus requester signal bundle for apb_lb_bridge.
// The slave modport is the bridge's view; master is the environment's view.
interface apb_lb_bridge_if
  import apb_lb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned STRB_W = DATA_W / 8
);

  // APB side
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  // Local-bus side
  logic [ADDR_W-1:0] lb_addr;
  logic [DATA_W-1:0] lb_wdata;
  logic [STRB_W-1:0] lb_wstrb;
  logic              lb_wen;
  logic              lb_wready;
  logic              lb_ren;
  logic [DATA_W-1:0] lb_rdata;
  logic              lb_rvalid;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr,
    output lb_addr, lb_wdata, lb_wstrb, lb_wen, lb_ren,
    input  lb_wready, lb_rdata, lb_rvalid
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr,
    input  lb_addr, lb_wdata, lb_wstrb, lb_wen, lb_ren,
    output lb_wready, lb_rdata, lb_rvalid
  );

endinterface

// File: rtl/apb_lb_timeout.sv
// Local-bus response watchdog: counts cycles while enabled and pulses
// o_expire on the TIMEOUT_CYCLES-th enabled cycle since the last clear.
module apb_lb_timeout
  import apb_lb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic pclk,
  input  logic preset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == CntW'(TIMEOUT_CYCLES - 1));

  // Count enabled cycles; hold once expired so the count never wraps.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/apb_lb_bridge.sv
// APB4 completer that turns each transfer into one local-bus request and
// stretches the access phase until the local bus answers. Misaligned
// addresses are rejected with pslverr without touching the local bus.
// Optional LB response timeout: define APB_LB_BRIDGE_TIMEOUT_EN.
module apb_lb_bridge
  import apb_lb_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned STRB_W         = DATA_W / 8,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic           pclk,
  input  logic           preset,
  apb_lb_bridge_if.slave bus
);

  localparam int unsigned AlignW = $clog2(STRB_W);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [STRB_W-1:0] r_wstrb, w_wstrb_nxt;
  logic              r_wen, w_wen_nxt;
  logic              r_ren, w_ren_nxt;
  logic              r_pready, w_pready_nxt;
  logic              r_pslverr, w_pslverr_nxt;
  logic [DATA_W-1:0] r_prdata, w_prdata_nxt;

  logic w_misaligned;
  logic w_tmo_clr;
  logic w_expire;

  assign w_misaligned = |bus.paddr[AlignW-1:0];

`ifdef APB_LB_BRIDGE_TIMEOUT_EN
  apb_lb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .pclk    (pclk),
    .preset  (preset),
    .i_en    (r_state == REQ),
    .i_clr   (w_tmo_clr),
    .o_expire(w_expire)
  );
`else
  // Without the watchdog REQ waits for the local bus indefinitely.
  logic w_unused_tmo;
  assign w_unused_tmo = w_tmo_clr ^ (TIMEOUT_CYCLES != 0);
  assign w_expire     = 1'b0;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_wen_nxt     = r_wen;
    w_ren_nxt     = r_ren;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = '0;
    w_tmo_clr     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          w_addr_nxt  = bus.paddr;
          w_wdata_nxt = bus.pwdata;
          w_wstrb_nxt = bus.pwrite ? bus.pstrb : '0;
          if (w_misaligned) begin
            w_state_nxt   = RESP;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = 1'b1;
          end else begin
            w_state_nxt = REQ;
            w_wen_nxt   = bus.pwrite;
            w_ren_nxt   = !bus.pwrite;
            w_tmo_clr   = 1'b1;
          end
        end
      end
      REQ: begin
        // A response in the expiry cycle takes precedence over the timeout.
        if (r_wen && bus.lb_wready) begin
          w_state_nxt  = RESP;
          w_wen_nxt    = 1'b0;
          w_pready_nxt = 1'b1;
        end else if (r_ren && bus.lb_rvalid) begin
          w_state_nxt  = RESP;
          w_ren_nxt    = 1'b0;
          w_pready_nxt = 1'b1;
          w_prdata_nxt = bus.lb_rdata;
        end else if (w_expire) begin
          w_state_nxt   = RESP;
          w_wen_nxt     = 1'b0;
          w_ren_nxt     = 1'b0;
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_wen_nxt   = 1'b0;
        w_ren_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any LB request in flight.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wen     <= 1'b0;
      r_ren     <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_wen     <= w_wen_nxt;
      r_ren     <= w_ren_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_prdata  <= w_prdata_nxt;
    end
  end

  assign bus.prdata   = r_prdata;
  assign bus.pready   = r_pready;
  assign bus.pslverr  = r_pslverr;
  assign bus.lb_addr  = r_addr;
  assign bus.lb_wdata = r_wdata;
  assign bus.lb_wstrb = r_wstrb;
  assign bus.lb_wen   = r_wen;
  assign bus.lb_ren   = r_ren;

endmodule
